// File: rtl/mo_to_std_pkg.sv
// Shared Kyber parameters used by the Montgomery-to-standard converter and the
// Barrett reduction pipeline.
package mo_to_std_pkg;

  localparam int unsigned DATA_WIDTH        = 12;
  localparam int unsigned Q                 = 3329;
  localparam int unsigned MO_R_LOG          = 12;
  localparam int unsigned BARRETT_M         = 20642678;  // floor(2^36 / Q)
  localparam int unsigned BARRETT_M_WIDTH   = 25;
  localparam int unsigned BARRETT_SHIFT     = 36;
  localparam int unsigned MO_TO_STD_LATENCY = 4;

  typedef logic signed [DATA_WIDTH-1:0] coef_t;

endpackage

// File: rtl/barrett_reduce.sv
// Three-stage Barrett reduction of an unsigned input modulo Modulus.
// Stage enables come from the caller, which owns the valid/ready chain.
// Centered = 1 maps results above Modulus/2 to the negative representative.
module barrett_reduce import mo_to_std_pkg::*; #(
  parameter int unsigned InWidth  = DATA_WIDTH + MO_R_LOG,
  parameter int unsigned OutWidth = DATA_WIDTH,
  parameter int unsigned Modulus  = Q,
  parameter int unsigned BarrettM = BARRETT_M,
  parameter int unsigned MWidth   = BARRETT_M_WIDTH,
  parameter int unsigned Shift    = BARRETT_SHIFT,
  parameter bit          Centered = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_s2,
  input  logic                en_s3,
  input  logic                en_s4,
  input  logic [InWidth-1:0]  a,
  output logic [OutWidth-1:0] res
);

  localparam int unsigned ProdWidth = InWidth + MWidth;
  localparam int unsigned QhWidth   = ProdWidth - Shift;
  // Remainder before correction lies in [0, 2*Modulus-1].
  localparam int unsigned RWidth    = OutWidth + 2;

  logic [ProdWidth-1:0] prod;
  logic [QhWidth-1:0]   qh_d, qh_q;
  logic [InWidth-1:0]   p_q, qq, r_full;
  logic [RWidth-1:0]    r_d, r_q, corr;
  logic [OutWidth-1:0]  res_d, res_q;

  // S2: quotient estimate; it undershoots the true quotient by at most one.
  always_comb begin
    prod = ProdWidth'(a) * ProdWidth'(BarrettM);
    qh_d = QhWidth'(prod >> Shift);
  end

  // S3: remainder against the estimated quotient; upper bits are zero by construction.
  always_comb begin
    qq     = InWidth'(qh_q) * InWidth'(Modulus);
    r_full = p_q - qq;
    r_d    = RWidth'(r_full);
  end

  // S4: single conditional subtraction, then optional recentering.
  always_comb begin
    corr  = (r_q >= RWidth'(Modulus)) ? r_q - RWidth'(Modulus) : r_q;
    res_d = OutWidth'(corr);
    if (Centered && (corr > RWidth'(Modulus / 2))) begin
      res_d = OutWidth'(corr - RWidth'(Modulus));
    end
  end

  // Stage registers, each loading only when its stage loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q   <= '0;
      qh_q  <= '0;
      r_q   <= '0;
      res_q <= '0;
    end else begin
      if (en_s2) begin
        p_q  <= a;
        qh_q <= qh_d;
      end
      if (en_s3) begin
        r_q <= r_d;
      end
      if (en_s4) begin
        res_q <= res_d;
      end
    end
  end

  assign res = res_q;

endmodule

// File: rtl/mo_to_std.sv
// Elastic 4-stage converter from the Montgomery domain to the standard domain:
// out = in * 2^12 mod Q. Valid/ready on both sides, bubbles collapse.
// Optional macro MO_CENTERED_OUT_EN: output is signed in [-(Q-1)/2, (Q-1)/2].
module mo_to_std #(
  parameter int unsigned DATA_WIDTH = mo_to_std_pkg::DATA_WIDTH,
  parameter int unsigned Q          = mo_to_std_pkg::Q
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
`ifdef MO_CENTERED_OUT_EN
  output logic signed [DATA_WIDTH-1:0] out_data,
`else
  output logic        [DATA_WIDTH-1:0] out_data,
`endif
  output logic                         out_valid,
  input  logic                         out_ready
);

  import mo_to_std_pkg::*;

  localparam int unsigned Stages = MO_TO_STD_LATENCY;
  localparam int unsigned PWidth = DATA_WIDTH + MO_R_LOG;
`ifdef MO_CENTERED_OUT_EN
  localparam bit CenteredOut = 1'b1;
`else
  localparam bit CenteredOut = 1'b0;
`endif

  // Index 0 is stage 1 (normalize), index Stages-1 is the output stage.
  logic [Stages-1:0]     v_d, v_q, ld;
  logic [DATA_WIDTH:0]   in_ext, t_full;
  logic [DATA_WIDTH-1:0] t_d, t_q;
  logic [PWidth-1:0]     p;
  logic [DATA_WIDTH-1:0] res;

  // Backward ready: a stage loads when empty or when its successor loads.
  always_comb begin
    ld[Stages-1] = ~v_q[Stages-1] | out_ready;
    for (int i = Stages - 2; i >= 0; i--) begin
      ld[i] = ~v_q[i] | ld[i+1];
    end
  end

  assign in_ready = ld[0];

  // Valid bits shift forward wherever the receiving stage loads.
  always_comb begin
    v_d = v_q;
    if (ld[0]) begin
      v_d[0] = in_valid;
    end
    for (int i = 1; i < Stages; i++) begin
      if (ld[i]) begin
        v_d[i] = v_q[i-1];
      end
    end
  end

  // Valid chain register; reset empties the pipe immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  // S1: fold the centered input into [0, Q-1].
  always_comb begin
    in_ext = {in_data[DATA_WIDTH-1], in_data};
    t_full = in_data[DATA_WIDTH-1] ? in_ext + (DATA_WIDTH + 1)'(Q) : in_ext;
    t_d    = DATA_WIDTH'(t_full);
  end

  // S1 data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q <= '0;
    end else if (ld[0]) begin
      t_q <= t_d;
    end
  end

  // Multiplying by R is a plain shift of the normalized value.
  assign p = {t_q, {MO_R_LOG{1'b0}}};

  barrett_reduce #(
    .InWidth  (PWidth),
    .OutWidth (DATA_WIDTH),
    .Modulus  (Q),
    .Centered (CenteredOut)
  ) u_barrett (
    .clk   (clk),
    .rst   (rst),
    .en_s2 (ld[1]),
    .en_s3 (ld[2]),
    .en_s4 (ld[3]),
    .a     (p),
    .res   (res)
  );

  assign out_data  = res;
  assign out_valid = v_q[Stages-1];

endmodule

// File: tb/tb_mo_to_std.sv
// Self-checking bench for mo_to_std against an arithmetic reference model.
module tb_mo_to_std;

  import mo_to_std_pkg::*;

  localparam int Qi   = 3329;
  localparam int Half = 1664;

  logic  clk      = 1'b0;
  logic  rst      = 1'b1;
  coef_t in_data  = '0;
  logic  in_valid = 1'b0;
  logic  in_ready;
`ifdef MO_CENTERED_OUT_EN
  logic signed [11:0] out_data;
`else
  logic [11:0] out_data;
`endif
  logic out_valid;
  logic out_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mo_to_std dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic int cen(input int v);
`ifdef MO_CENTERED_OUT_EN
    return (v > Half) ? v - Qi : v;
`else
    return v;
`endif
  endfunction

  // Reference: x mod Q into [0, Q-1], times 2^12, mod Q.
  function automatic int model(input int x);
    int t;
    t = ((x % Qi) + Qi) % Qi;
    return cen((t * 4096) % Qi);
  endfunction

  // One clock: sample handshakes at the negedge, return #1 after the posedge.
  task automatic step(output bit acc, output bit emit, output logic [11:0] od);
    @(negedge clk);
    acc  = in_valid && in_ready;
    emit = out_valid && out_ready;
    od   = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #12;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    total++;
    if (out_data !== 12'd0) begin
      bad++; $display("FAIL reset_out_data: got %0d want 0", out_data);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int xs[5] = '{0, 1, -1, 1664, -1664};
    int ys[5] = '{0, 767, 2562, 1281, 2048};
    logic [11:0] want;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data  = 12'(xs[i]);
      in_valid = 1'b1;
      want     = 12'(cen(ys[i]));
      for (int k = 1; k <= 4; k++) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (k < 4) begin
          total++;
          if (out_valid !== 1'b0) begin
            bad++; $display("FAIL single_early in=%0d cycle=%0d: got valid %b want 0",
                            xs[i], k, out_valid);
          end
        end
      end
      total++;
      if (out_valid !== 1'b1 || out_data !== want) begin
        bad++; $display("FAIL single in=%0d: got valid=%b data=%0d want valid=1 data=%0d",
                        xs[i], out_valid, out_data, want);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sweep();
    int q[$];
    int x = -1664;
    int n = 3329;
    int got = 0;
    int steps = 0;
    bit acc, emit;
    logic [11:0] od, want;
    out_ready = 1'b1;
    while (got < n && steps < n + 100) begin
      in_valid = (x <= 1664);
      in_data  = 12'(x);
      step(acc, emit, od);
      steps++;
      if (emit) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL sweep_extra: got data=%0d want no output", od);
        end else begin
          want = 12'(q.pop_front());
          if (od !== want) begin
            bad++; $display("FAIL sweep item=%0d: got %0d want %0d", got, od, want);
          end
        end
        got++;
      end
      if (acc) begin
        q.push_back(model(x));
        x++;
      end
    end
    in_valid = 1'b0;
    total++;
    if (steps != n + 4 || got != n) begin
      bad++; $display("FAIL sweep_throughput: got %0d cycles for %0d outputs want %0d cycles",
                      steps, got, n + 4);
    end
  endtask

  task automatic test_stall();
    int stall_exp[6] = '{767, 1534, 2301, 3068, 506, 1273};
    int idx = 0;
    int n = 0;
    int steps = 0;
    bit acc, emit;
    logic [11:0] od, want;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 6);
      in_data  = 12'(idx + 1);
      step(acc, emit, od);
      if (acc) idx++;
    end
    total++;
    if (idx != 4) begin
      bad++; $display("FAIL stall_accepted: got %0d items want 4", idx);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready);
    end
    want = 12'(cen(767));
    total++;
    if (out_valid !== 1'b1 || out_data !== want) begin
      bad++; $display("FAIL stall_head: got valid=%b data=%0d want valid=1 data=%0d",
                      out_valid, out_data, want);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_full_ready: got %b want 1", in_ready);
    end
    while (n < 6 && steps < 40) begin
      in_valid = (idx < 6);
      in_data  = 12'(idx + 1);
      step(acc, emit, od);
      steps++;
      if (emit) begin
        want = 12'(cen(stall_exp[n]));
        total++;
        if (od !== want) begin
          bad++; $display("FAIL stall_drain item=%0d: got %0d want %0d", n, od, want);
        end
        n++;
      end
      if (acc) idx++;
    end
    in_valid = 1'b0;
    total++;
    if (n != 6 || idx != 6 || out_valid !== 1'b0) begin
      bad++; $display("FAIL stall_count: got out=%0d in=%0d trailing_valid=%b want 6 6 0",
                      n, idx, out_valid);
    end
  endtask

  task automatic test_random();
    int q[$];
    int n = 10000;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int x;
    bit acc, emit;
    logic prev_stall = 1'b0;
    logic [11:0] prev_data = '0;
    logic [11:0] want;
    while (got < n && cyc < 40000) begin
      in_valid  = (sent < n) && ($urandom_range(1) == 1);
      x         = int'($urandom_range(3328)) - 1664;
      in_data   = 12'(x);
      out_ready = ($urandom_range(1) == 1);
      @(negedge clk);
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          bad++; $display("FAIL random_hold cycle=%0d: got valid=%b data=%0d want valid=1 data=%0d",
                          cyc, out_valid, out_data, prev_data);
        end
      end
      acc        = in_valid && in_ready;
      emit       = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (emit) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL random_extra: got data=%0d want no output", out_data);
        end else begin
          want = 12'(q.pop_front());
          if (out_data !== want) begin
            bad++; $display("FAIL random item=%0d: got %0d want %0d", got, out_data, want);
          end
        end
        got++;
      end
      if (acc) begin
        q.push_back(model(x));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (got != n || q.size() != 0) begin
      bad++; $display("FAIL random_count: got %0d outputs pending=%0d want %0d pending=0",
                      got, q.size(), n);
    end
  endtask

  task automatic test_midreset();
    bit acc, emit;
    logic [11:0] od, want;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = 12'(10 * (c + 1));
      step(acc, emit, od);
    end
    in_valid = 1'b0;
    step(acc, emit, od);
    step(acc, emit, od);
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL midreset_loaded: got valid %b want 1", out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midreset_flush: got valid=%b ready=%b want valid=0 ready=1",
                      out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_data   = 12'sd5;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step(acc, emit, od);
    in_valid = 1'b0;
    total++;
    if (!acc || emit) begin
      bad++; $display("FAIL midreset_accept: got acc=%b emit=%b want acc=1 emit=0", acc, emit);
    end
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k < 4) begin
        total++;
        if (out_valid !== 1'b0) begin
          bad++; $display("FAIL midreset_stale cycle=%0d: got valid %b want 0", k, out_valid);
        end
      end
    end
    want = 12'(model(5));
    total++;
    if (out_valid !== 1'b1 || out_data !== want) begin
      bad++; $display("FAIL midreset_first: got valid=%b data=%0d want valid=1 data=%0d",
                      out_valid, out_data, want);
    end
    @(posedge clk);
    #1;
  endtask

  // Feed Montgomery products a*b*R^-1 mod Q; the converter must return a*b mod Q.
  task automatic test_chain();
    int q[$];
    int inv = 0;
    int n = 200;
    int sent = 0;
    int got = 0;
    int steps = 0;
    int a, b, mont, expv;
    bit acc, emit;
    logic [11:0] od, want;
    for (int m = 1; m < Qi; m++) begin
      if ((m * 4096) % Qi == 1) inv = m;
    end
    a    = int'($urandom_range(Qi - 1));
    b    = int'($urandom_range(Qi - 1));
    out_ready = 1'b1;
    while (got < n && steps < n + 100) begin
      mont = (((a * b) % Qi) * inv) % Qi;
      if (mont > Half) mont -= Qi;
      expv     = cen((a * b) % Qi);
      in_valid = (sent < n);
      in_data  = 12'(mont);
      step(acc, emit, od);
      steps++;
      if (emit) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL chain_extra: got data=%0d want no output", od);
        end else begin
          want = 12'(q.pop_front());
          if (od !== want) begin
            bad++; $display("FAIL chain item=%0d: got %0d want %0d", got, od, want);
          end
        end
        got++;
      end
      if (acc) begin
        q.push_back(expv);
        sent++;
        a = int'($urandom_range(Qi - 1));
        b = int'($urandom_range(Qi - 1));
      end
    end
    in_valid = 1'b0;
    total++;
    if (got != n) begin
      bad++; $display("FAIL chain_count: got %0d outputs want %0d", got, n);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_stall();
    test_random();
    test_midreset();
    test_chain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
